parking_time_log: RTL and testbench

PARKING_TIME_LOG -- requirements
Module: parking_time_log

---
 rtl/parking_time_log.sv | 116 +++++++++++
 tb/tb_parking_time_log.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/parking_time_log.sv
// Parking lot slot allocator and entry/exit time logger.
// Entries take the lowest free slot; exits report the stored entry time alongside the exit time.
module parking_time_log #(
    parameter int NUM_SLOTS = 8,
    parameter int TICK_DIV  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         car_enter,
    input  logic                         car_exit,
    input  logic [$clog2(NUM_SLOTS)-1:0] exit_slot,
    output logic                         enter_ack,
    output logic [$clog2(NUM_SLOTS)-1:0] assigned_slot,
    output logic                         enter_err,
    output logic                         out_valid,
    output logic [7:0]                   time_in,
    output logic [7:0]                   time_out,
    output logic                         exit_err,
    output logic [$clog2(NUM_SLOTS):0]   occupancy,
    output logic                         full
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int OW = SW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]        presc;
    logic [7:0]           time_cnt;
    logic [NUM_SLOTS-1:0] occ_map;
    logic [NUM_SLOTS-1:0] map_next;
    logic [7:0]           entry_time [NUM_SLOTS];

    logic          tick;
    logic          lot_full;
    logic [SW-1:0] free_slot;
    logic          enter_ok;
    logic          enter_rej;
    logic          exit_ok;
    logic          exit_bad;
    logic [OW-1:0] occ_next;

    // Request/response contract: car_enter and car_exit are single-cycle requests with no
    // backpressure; each produces exactly one single-cycle response pulse on the following
    // cycle (enter_ack or enter_err; out_valid or exit_err). Data outputs hold between pulses.

    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign lot_full  = &occ_map;
    assign enter_ok  = car_enter && !lot_full;
    assign enter_rej = car_enter && lot_full;
    assign exit_ok   = car_exit && occ_map[exit_slot];
    assign exit_bad  = car_exit && !occ_map[exit_slot];

    // Allocation looks at the map as it stood before any same-cycle exit.
    always_comb begin
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_map[i]) begin
                free_slot = SW'(i);
            end
        end
    end

    always_comb begin
        map_next = occ_map;
        if (exit_ok) begin
            map_next[exit_slot] = 1'b0;
        end
        if (enter_ok) begin
            map_next[free_slot] = 1'b1;
        end
    end

    assign occ_next = occupancy + OW'(enter_ok) - OW'(exit_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc         <= '0;
            time_cnt      <= '0;
            occ_map       <= '0;
            enter_ack     <= 1'b0;
            assigned_slot <= '0;
            enter_err     <= 1'b0;
            out_valid     <= 1'b0;
            time_in       <= '0;
            time_out      <= '0;
            exit_err      <= 1'b0;
            occupancy     <= '0;
            full          <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + PW'(1);
            time_cnt  <= tick ? time_cnt + 8'd1 : time_cnt;
            occ_map   <= map_next;
            enter_ack <= enter_ok;
            enter_err <= enter_rej;
            out_valid <= exit_ok;
            exit_err  <= exit_bad;
            occupancy <= occ_next;
            full      <= (occ_next == OW'(NUM_SLOTS));
            if (enter_ok) begin
                assigned_slot <= free_slot;
            end
            if (exit_ok) begin
                time_in  <= entry_time[exit_slot];
                time_out <= time_cnt;
            end
        end
    end

    // Stored times need no reset: a slot's time is only read after its occupied bit is set.
    always_ff @(posedge clk) begin
        if (!rst && enter_ok) begin
            entry_time[free_slot] <= time_cnt;
        end
    end

endmodule

// File: tb/tb_parking_time_log.sv
// Scoreboard bench for parking_time_log: directed requests push expected response records,
// an independent monitor pops and compares whenever a response pulse appears.
module tb_parking_time_log;

    localparam int RW = 28;

    logic       clk;
    logic       rst;
    logic       car_enter;
    logic       car_exit;
    logic [2:0] exit_slot;
    logic       enter_ack;
    logic [2:0] assigned_slot;
    logic       enter_err;
    logic       out_valid;
    logic [7:0] time_in;
    logic [7:0] time_out;
    logic       exit_err;
    logic [3:0] occupancy;
    logic       full;

    logic [7:0]    tb_time;
    logic [RW-1:0] exp_q[$];
    int            n_checks;
    int            n_pass;

    parking_time_log #(.NUM_SLOTS(8), .TICK_DIV(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .car_enter     (car_enter),
        .car_exit      (car_exit),
        .exit_slot     (exit_slot),
        .enter_ack     (enter_ack),
        .assigned_slot (assigned_slot),
        .enter_err     (enter_err),
        .out_valid     (out_valid),
        .time_in       (time_in),
        .time_out      (time_out),
        .exit_err      (exit_err),
        .occupancy     (occupancy),
        .full          (full)
    );

    // clock / reset-synchronised time reference (TICK_DIV=1: one unit per cycle)
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_time <= 8'd0;
        else     tb_time <= tb_time + 8'd1;
    end

    function automatic logic [RW-1:0] dut_rec();
        return {enter_ack, assigned_slot, enter_err, out_valid, time_in, time_out,
                exit_err, occupancy, full};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (ack,slot,eerr,ov,ti,to,xerr,occ,full)",
                      name, act, exp);
    endtask

    // monitor: any response pulse consumes one expected record
    always @(negedge clk) begin
        if (enter_ack || enter_err || out_valid || exit_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", dut_rec(), '0);
            end else begin
                check("response", dut_rec(), exp_q.pop_front());
            end
        end
    end

    // driver tasks (called at a negedge)
    task automatic do_reset(input bit with_enter);
        rst       = 1'b1;
        car_enter = with_enter;
        car_exit  = 1'b0;
        @(negedge clk);
        car_enter = 1'b0;
        check("reset_outputs", dut_rec(), '0);
        @(negedge clk);
        check("reset_hold", dut_rec(), '0);
        rst = 1'b0;
    endtask

    task automatic goto_time(input logic [7:0] t);
        int n = 0;
        while (tb_time != t && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tb_time != t) check("goto_time_timeout", {20'd0, tb_time}, {20'd0, t});
    endtask

    task automatic issue(input bit en, input bit ex, input logic [2:0] slot,
                         input bit e_ack, input logic [2:0] e_slot, input bit e_eerr,
                         input bit e_ov, input logic [7:0] e_ti, input logic [7:0] e_to,
                         input bit e_xerr, input logic [3:0] e_occ);
        car_enter = en;
        car_exit  = ex;
        exit_slot = slot;
        exp_q.push_back({e_ack, e_slot, e_eerr, e_ov, e_ti, e_to, e_xerr, e_occ, (e_occ == 4'd8)});
        @(negedge clk);
        car_enter = 1'b0;
        car_exit  = 1'b0;
        exit_slot = 3'd0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        car_enter = 1'b0;
        car_exit  = 1'b0;
        exit_slot = 3'd0;
        @(negedge clk);

        // first entry at time 3
        do_reset(1'b0);
        goto_time(8'd3);
        issue(1, 0, 3'd0,  1, 3'd0, 0, 0, 8'd0, 8'd0, 0, 4'd1);

        // entry at 1, exit at 25
        do_reset(1'b0);
        goto_time(8'd1);
        issue(1, 0, 3'd0,  1, 3'd0, 0, 0, 8'd0, 8'd0, 0, 4'd1);
        goto_time(8'd25);
        issue(0, 1, 3'd0,  0, 3'd0, 0, 1, 8'd1, 8'd25, 0, 4'd0);

        // entry at 250, exit after wrap at 4
        do_reset(1'b0);
        goto_time(8'd250);
        issue(1, 0, 3'd0,  1, 3'd0, 0, 0, 8'd0, 8'd0, 0, 4'd1);
        goto_time(8'd4);
        issue(0, 1, 3'd0,  0, 3'd0, 0, 1, 8'd250, 8'd4, 0, 4'd0);

        // fill the lot back-to-back (times 10..17), then reject a ninth car at 18
        do_reset(1'b0);
        goto_time(8'd10);
        for (int i = 0; i < 8; i++) begin
            issue(1, 0, 3'd0,  1, i[2:0], 0, 0, 8'd0, 8'd0, 0, 4'(i + 1));
        end
        issue(1, 0, 3'd0,  0, 3'd7, 1, 0, 8'd0, 8'd0, 0, 4'd8);

        // full lot: simultaneous enter + exit(3) at 30; then slot 3 is reused
        goto_time(8'd30);
        issue(1, 1, 3'd3,  0, 3'd7, 1, 1, 8'd13, 8'd30, 0, 4'd7);
        issue(1, 0, 3'd0,  1, 3'd3, 0, 0, 8'd13, 8'd30, 0, 4'd8);

        // exit of a free slot, then mid-run reset with a concurrent entry
        do_reset(1'b0);
        goto_time(8'd2);
        issue(1, 0, 3'd0,  1, 3'd0, 0, 0, 8'd0, 8'd0, 0, 4'd1);
        goto_time(8'd6);
        issue(0, 1, 3'd0,  0, 3'd0, 0, 1, 8'd2, 8'd6, 0, 4'd0);
        issue(0, 1, 3'd5,  0, 3'd0, 0, 0, 8'd2, 8'd6, 1, 4'd0);
        issue(1, 0, 3'd0,  1, 3'd0, 0, 0, 8'd2, 8'd6, 0, 4'd1);
        issue(1, 0, 3'd0,  1, 3'd1, 0, 0, 8'd2, 8'd6, 0, 4'd2);
        do_reset(1'b1);
        issue(1, 0, 3'd0,  1, 3'd0, 0, 0, 8'd0, 8'd0, 0, 4'd1);

        repeat (3) @(negedge clk);
        check("pending_responses", RW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
